// File: rtl/pio_rx_dsp_pkg.sv
// pio_rx_dsp_pkg
//   Shared definitions for the PIO receive-side router.
//   - FSM state encodings for the packet-tracking state machine
//   - reset value of the select parity bit. The select register resets to
//     all-zero, so its parity bit must reset to 1 to keep odd parity.
package pio_rx_dsp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic SEL_P_INIT = 1'b1;

endpackage

// File: rtl/pio_rx_dsp_dec.sv
// pio_rx_dsp_dec
//   Combinational destination decoder.
//   Ports:
//     in_dest     in   IDW  destination ID from the first beat of a packet
//     sel_onehot  out  N    one-hot port select; all-zero for an illegal ID
//     dest_ok     out  1    in_dest < N
//     sel_p       out  1    parity bit giving odd parity over {sel_onehot, sel_p}
module pio_rx_dsp_dec #(
  parameter int N   = 6,
  parameter int IDW = 3
) (
  input  logic [IDW-1:0] in_dest,
  output logic [N-1:0]   sel_onehot,
  output logic           dest_ok,
  output logic           sel_p
);

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(in_dest) == i) sel_onehot[i] = 1'b1;
    end
    dest_ok = (int'(in_dest) < N);
    sel_p   = ~^sel_onehot;
  end

endmodule

// File: rtl/pio_rx_dsp.sv
// pio_rx_dsp
//   Receive-side PIO router. Routes each inbound packet to one of N consumers
//   through a single registered output stage. The destination is locked on
//   the first beat; packets with an illegal destination are discarded and
//   counted. The held select register carries an odd-parity bit.
//   Ports:
//     user_clk   in   1     clock
//     reset      in   1     asynchronous active-high reset
//     in_valid   in   1     inbound beat valid
//     in_ready   out  1     inbound beat accepted on in_valid & in_ready
//     in_dest    in   IDW   destination ID, sampled on the first beat only
//     in_data    in   DW    beat payload
//     in_last    in   1     final beat of packet
//     out_valid  out  N     one-hot per-port valid
//     out_ready  in   N     per-port ready
//     out_data   out  DW    shared payload bus
//     out_last   out  1     shared last flag
//     drop_err   out  1     pulse on the first beat of an illegal-ID packet
//     drop_cnt   out  CNTW  saturating count of dropped packets
//     pe         out  1     parity error on the held select register
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for the first beat of a packet
//   FWD   | mid-packet, beats forwarded to the locked port
//   DROP  | mid-packet with an illegal ID, beats accepted and discarded
module pio_rx_dsp
  import pio_rx_dsp_pkg::*;
#(
  parameter int N    = 6,
  parameter int DW   = 64,
  parameter int IDW  = 3,
  parameter int CNTW = 16
) (
  input  logic            user_clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IDW-1:0]  in_dest,
  input  logic [DW-1:0]   in_data,
  input  logic            in_last,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic            drop_err,
  output logic [CNTW-1:0] drop_cnt,
  output logic            pe
);

  logic [1:0]   state;
  logic         out_vld_r;
  logic [N-1:0] out_sel_r;
  logic         out_sel_p;

  logic [N-1:0] sel_onehot;
  logic         dest_ok;
  logic         sel_p;

  logic consumed;
  logic accept;
  logic first_beat;
  logic load;
  logic drop_first;

  pio_rx_dsp_dec #(
    .N   (N),
    .IDW (IDW)
  ) u_dec (
    .in_dest    (in_dest),
    .sel_onehot (sel_onehot),
    .dest_ok    (dest_ok),
    .sel_p      (sel_p)
  );

  assign out_valid  = out_sel_r & {N{out_vld_r}};
  assign consumed   = out_vld_r & (|(out_sel_r & out_ready));
  // Accepting while the held beat is being consumed gives 1 beat/cycle.
  assign in_ready   = ~reset & ((state == ST_DROP) | ~out_vld_r | consumed);
  assign accept     = in_valid & in_ready;
  assign first_beat = (state == ST_IDLE);
  assign load       = accept & ((first_beat & dest_ok) | (state == ST_FWD));
  assign drop_first = accept & first_beat & ~dest_ok;
  assign pe         = ~^{out_sel_r, out_sel_p};

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_vld_r <= 1'b0;
      out_sel_r <= '0;
      out_sel_p <= SEL_P_INIT;
      out_data  <= '0;
      out_last  <= 1'b0;
      drop_err  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      drop_err <= drop_first;
      if (drop_first && (drop_cnt != {CNTW{1'b1}})) drop_cnt <= drop_cnt + 1'b1;

      if (load) begin
        out_data  <= in_data;
        out_last  <= in_last;
        out_vld_r <= 1'b1;
      end else if (consumed) begin
        out_vld_r <= 1'b0;
      end

      // The select is only rewritten on a new packet; it is held after the
      // last beat drains so the parity check keeps covering it.
      if (load && first_beat) begin
        out_sel_r <= sel_onehot;
        out_sel_p <= sel_p;
      end

      case (state)
        ST_IDLE: if (accept && !in_last) state <= dest_ok ? ST_FWD : ST_DROP;
        ST_FWD:  if (accept && in_last)  state <= ST_IDLE;
        ST_DROP: if (accept && in_last)  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_rx_dsp.sv
module tb_pio_rx_dsp;

  localparam int N    = 6;
  localparam int DW   = 64;
  localparam int IDW  = 3;
  localparam int CNTW = 8;
  localparam logic [N-1:0] ALL_RDY = {N{1'b1}};

  logic            user_clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [IDW-1:0]  in_dest;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            drop_err;
  logic [CNTW-1:0] drop_cnt;
  logic            pe;

  always #5 user_clk = ~user_clk;

  pio_rx_dsp #(.N(N), .DW(DW), .IDW(IDW), .CNTW(CNTW)) dut (
    .user_clk  (user_clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .drop_err  (drop_err),
    .drop_cnt  (drop_cnt),
    .pe        (pe)
  );

  // Reference model: packet-level view. Beats routed to a consumer are queued
  // in order; the head of the queue is what the consumer side should see.
  typedef struct {
    int              port;
    logic [DW-1:0]   data;
    logic            last;
  } beat_t;

  beat_t exp_q[$];
  bit    m_in_pkt;
  bit    m_drop;
  int    m_port;
  int    m_cnt;
  bit    m_err;

  int total = 0;
  int bad   = 0;

  logic [N-1:0]    obs_valid, exp_valid;
  logic [DW-1:0]   obs_data, exp_data;
  logic            obs_last, exp_last, obs_ir, exp_ir, obs_err, exp_err, obs_pe;
  logic [CNTW-1:0] obs_cnt, exp_cnt;

  task automatic model_reset();
    exp_q.delete();
    m_in_pkt = 0;
    m_drop   = 0;
    m_port   = 0;
    m_cnt    = 0;
    m_err    = 0;
  endtask

  // Drive one cycle, capture DUT and model views, then advance the model
  // across the coming clock edge. Comparisons are made by the callers.
  task automatic tick(input logic v, input logic [IDW-1:0] d, input logic [DW-1:0] dat,
                      input logic l, input logic [N-1:0] rdy, output bit acc);
    bit head_rdy;
    @(negedge user_clk);
    in_valid  = v;
    in_dest   = d;
    in_data   = dat;
    in_last   = l;
    out_ready = rdy;
    #1;
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_last  = out_last;
    obs_ir    = in_ready;
    obs_err   = drop_err;
    obs_cnt   = drop_cnt;
    obs_pe    = pe;

    exp_valid = '0;
    exp_data  = '0;
    exp_last  = 1'b0;
    head_rdy  = 0;
    if (exp_q.size() > 0) begin
      exp_valid = {{(N-1){1'b0}}, 1'b1} << exp_q[0].port;
      exp_data  = exp_q[0].data;
      exp_last  = exp_q[0].last;
      head_rdy  = rdy[exp_q[0].port];
    end
    exp_ir  = (m_in_pkt && m_drop) || (exp_q.size() == 0) || head_rdy;
    exp_err = m_err;
    exp_cnt = m_cnt[CNTW-1:0];

    acc   = v && exp_ir;
    m_err = 0;
    if (head_rdy) void'(exp_q.pop_front());
    if (acc) begin
      if (!m_in_pkt) begin
        if (d < N) begin
          m_drop = 0;
          m_port = int'(d);
        end else begin
          m_drop = 1;
          m_err  = 1;
          if (m_cnt < (2**CNTW) - 1) m_cnt++;
        end
      end
      if (!m_drop) exp_q.push_back('{m_port, dat, l});
      m_in_pkt = !l;
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic apply_reset();
    in_valid  = 1'b0;
    in_dest   = '0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = ALL_RDY;
    reset     = 1'b1;
    model_reset();
    repeat (3) @(negedge user_clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = 1'b1;
    in_dest   = 3'd1;
    in_data   = rnd64();
    in_last   = 1'b1;
    out_ready = ALL_RDY;
    reset     = 1'b1;
    model_reset();
    repeat (2) @(negedge user_clk);
    #1;
    total++;
    if ({out_valid, out_data, out_last, drop_err, drop_cnt, pe, in_ready} !== '0) begin
      bad++;
      $display("FAIL reset_vals: got v=%b d=%h l=%b err=%b cnt=%0d pe=%b ir=%b, expected all 0",
               out_valid, out_data, out_last, drop_err, drop_cnt, pe, in_ready);
    end
    in_valid = 1'b0;
    @(negedge user_clk);
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single_beat();
    bit acc;
    for (int k = 0; k < N + 2; k++) begin
      if (k < N) tick(1'b1, IDW'(k), rnd64(), 1'b1, ALL_RDY, acc);
      else       tick(1'b0, '0, '0, 1'b0, ALL_RDY, acc);
      total++;
      if (obs_valid !== exp_valid || (exp_valid != 0 && {obs_last, obs_data} !== {exp_last, exp_data})) begin
        bad++;
        $display("FAIL single_out k=%0d: got v=%b l=%b d=%h expected v=%b l=%b d=%h",
                 k, obs_valid, obs_last, obs_data, exp_valid, exp_last, exp_data);
      end
      total++;
      if (obs_ir !== 1'b1) begin
        bad++;
        $display("FAIL single_ready k=%0d: got %b expected 1", k, obs_ir);
      end
    end
  endtask

  // Four-beat packet to port 2 with a misleading in_dest on later beats, and
  // port 2 stalled for three cycles in the middle.
  task automatic test_multibeat_stall();
    bit acc;
    int t = 0;
    for (int b = 0; b < 4; b++) begin
      logic [DW-1:0] dat = rnd64();
      int n = 0;
      do begin
        logic [N-1:0] rdy = (t >= 2 && t <= 4) ? 6'b111011 : ALL_RDY;
        tick(1'b1, (b == 0) ? 3'd2 : 3'd5, dat, b == 3, rdy, acc);
        t++;
        n++;
        total++;
        if (obs_valid !== exp_valid || (exp_valid != 0 && {obs_last, obs_data} !== {exp_last, exp_data})) begin
          bad++;
          $display("FAIL mb_out t=%0d: got v=%b l=%b d=%h expected v=%b l=%b d=%h",
                   t, obs_valid, obs_last, obs_data, exp_valid, exp_last, exp_data);
        end
        total++;
        if (obs_ir !== exp_ir) begin
          bad++;
          $display("FAIL mb_ready t=%0d: got %b expected %b", t, obs_ir, exp_ir);
        end
      end while (!acc && n < 20);
      if (!acc) begin
        bad++;
        $display("FAIL mb_timeout beat=%0d: got no accept expected accept", b);
      end
    end
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, '0, '0, 1'b0, ALL_RDY, acc);
      total++;
      if (obs_valid !== exp_valid || (exp_valid != 0 && {obs_last, obs_data} !== {exp_last, exp_data})) begin
        bad++;
        $display("FAIL mb_drain: got v=%b l=%b expected v=%b l=%b", obs_valid, obs_last, exp_valid, exp_last);
      end
    end
  endtask

  // Three-beat packet to illegal port 6, immediately followed by a two-beat
  // packet to port 1.
  task automatic test_drop();
    bit acc;
    for (int k = 0; k < 8; k++) begin
      if (k < 3)      tick(1'b1, 3'd6, rnd64(), k == 2, ALL_RDY, acc);
      else if (k < 5) tick(1'b1, 3'd1, rnd64(), k == 4, ALL_RDY, acc);
      else            tick(1'b0, '0, '0, 1'b0, ALL_RDY, acc);
      total++;
      if (obs_valid !== exp_valid || (exp_valid != 0 && {obs_last, obs_data} !== {exp_last, exp_data})) begin
        bad++;
        $display("FAIL drop_out k=%0d: got v=%b l=%b d=%h expected v=%b l=%b d=%h",
                 k, obs_valid, obs_last, obs_data, exp_valid, exp_last, exp_data);
      end
      total++;
      if ({obs_err, obs_cnt} !== {exp_err, exp_cnt} || obs_ir !== exp_ir) begin
        bad++;
        $display("FAIL drop_stat k=%0d: got err=%b cnt=%0d ir=%b expected err=%b cnt=%0d ir=%b",
                 k, obs_err, obs_cnt, obs_ir, exp_err, exp_cnt, exp_ir);
      end
    end
    total++;
    if (obs_cnt !== 8'd1) begin
      bad++;
      $display("FAIL drop_cnt_one: got %0d expected 1", obs_cnt);
    end
  endtask

  task automatic test_random();
    bit acc;
    for (int p = 0; p < 60; p++) begin
      int len = $urandom_range(1, 4);
      logic [IDW-1:0] dest = IDW'($urandom_range(0, 7));
      for (int b = 0; b < len; b++) begin
        logic [DW-1:0] dat = rnd64();
        int n = 0;
        do begin
          bit v = ($urandom_range(0, 3) != 0);
          logic [N-1:0] rdy = N'($urandom | $urandom);
          tick(v, (b == 0) ? dest : IDW'($urandom), dat, b == len - 1, rdy, acc);
          n++;
          total++;
          if (obs_valid !== exp_valid || (exp_valid != 0 && {obs_last, obs_data} !== {exp_last, exp_data})) begin
            bad++;
            $display("FAIL rnd_out p=%0d b=%0d: got v=%b l=%b d=%h expected v=%b l=%b d=%h",
                     p, b, obs_valid, obs_last, obs_data, exp_valid, exp_last, exp_data);
          end
          total++;
          if (obs_ir !== exp_ir || {obs_err, obs_cnt} !== {exp_err, exp_cnt}) begin
            bad++;
            $display("FAIL rnd_stat p=%0d: got ir=%b err=%b cnt=%0d expected ir=%b err=%b cnt=%0d",
                     p, obs_ir, obs_err, obs_cnt, exp_ir, exp_err, exp_cnt);
          end
          total++;
          if (obs_pe !== 1'b0) begin
            bad++;
            $display("FAIL rnd_pe: got %b expected 0", obs_pe);
          end
        end while (!acc && n < 50);
        if (!acc) begin
          bad++;
          $display("FAIL rnd_timeout p=%0d b=%0d: got no accept expected accept", p, b);
        end
      end
    end
    repeat (3) tick(1'b0, '0, '0, 1'b0, ALL_RDY, acc);
    total++;
    if (obs_valid !== '0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rnd_drain: got v=%b pending=%0d expected v=0 pending=0", obs_valid, exp_q.size());
    end
  endtask

  task automatic test_saturate();
    bit acc;
    int err_seen = 0;
    for (int k = 0; k < (2**CNTW) + 4; k++) begin
      tick(1'b1, IDW'($urandom_range(N, 7)), rnd64(), 1'b1, ALL_RDY, acc);
      if (obs_err === 1'b1) err_seen++;
      total++;
      if ({obs_err, obs_cnt} !== {exp_err, exp_cnt} || obs_valid !== '0) begin
        bad++;
        $display("FAIL sat_stat k=%0d: got err=%b cnt=%0d v=%b expected err=%b cnt=%0d v=0",
                 k, obs_err, obs_cnt, obs_valid, exp_err, exp_cnt);
      end
    end
    tick(1'b0, '0, '0, 1'b0, ALL_RDY, acc);
    total++;
    if (obs_cnt !== {CNTW{1'b1}} || obs_err !== exp_err || exp_err !== 1'b1) begin
      bad++;
      $display("FAIL sat_hold: got cnt=%0d err=%b expected cnt=%0d err=1", obs_cnt, obs_err, (2**CNTW) - 1);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    logic [DW-1:0] dat;
    tick(1'b1, 3'd3, rnd64(), 1'b0, '0, acc);
    tick(1'b1, 3'd0, rnd64(), 1'b0, '0, acc);
    total++;
    if (obs_valid !== 6'b001000 || obs_ir !== 1'b0) begin
      bad++;
      $display("FAIL mid_hold: got v=%b ir=%b expected v=001000 ir=0", obs_valid, obs_ir);
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({out_valid, out_data, out_last, drop_err, drop_cnt, pe, in_ready} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b d=%h l=%b err=%b cnt=%0d pe=%b ir=%b expected all 0",
               out_valid, out_data, out_last, drop_err, drop_cnt, pe, in_ready);
    end
    model_reset();
    @(negedge user_clk);
    reset = 1'b0;
    dat = rnd64();
    tick(1'b1, 3'd4, dat, 1'b1, ALL_RDY, acc);
    tick(1'b0, '0, '0, 1'b0, ALL_RDY, acc);
    total++;
    if (obs_valid !== 6'b010000 || obs_data !== dat || obs_last !== 1'b1 || obs_valid !== exp_valid) begin
      bad++;
      $display("FAIL mid_first: got v=%b d=%h l=%b expected v=010000 d=%h l=1", obs_valid, obs_data, obs_last, dat);
    end
    total++;
    if (obs_pe !== 1'b0 || obs_cnt !== '0) begin
      bad++;
      $display("FAIL mid_after: got pe=%b cnt=%0d expected pe=0 cnt=0", obs_pe, obs_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    apply_reset();
    test_single_beat();
    test_multibeat_stall();
    test_drop();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

endmodule
